conv_job_launcher: RTL and testbench

Host-side initiator for the binary-convolution accelerator's run/busy handshake. It launches a programmed number of back-to-back convolution jobs on the accelerator, waits for each to complete, then reads that job's result words from output SRAM and streams them out on a valid/ready port with an optional running checksum. It sits between the system controller and the accelerator top, driving the accelerator's run input and sharing the output SRAM read port when the accelerator is idle.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_job_launcher_if.sv | 14 +
 rtl/conv_rb_skid.sv | 48 ++++
 rtl/conv_job_launcher.sv | 205 ++++++++++++++++++++
 tb/tb_conv_job_launcher.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution job launcher.
// Parameter defaults live here so every file in the slice agrees on them.
package conv_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 4095;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_BUSY,
    S_READ,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/conv_job_launcher_if.sv
// Result-stream valid/ready bundle between the job launcher and its consumer.
interface conv_job_launcher_if
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/conv_rb_skid.sv
// Two-entry FIFO used as the SRAM read-return buffer; head is combinational
// from registered storage.
module conv_rb_skid #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the storage is reset because its head is a visible output.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/conv_job_launcher.sv
// Launches back-to-back accelerator jobs and streams each job's result words.
// Build option: CONV_LAUNCH_CHECKSUM_EN enables the running checksum.
module conv_job_launcher
  import conv_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [7:0]        job_count,
  input  logic [ADDR_W-1:0] result_base,
  input  logic [ADDR_W-1:0] result_len,
  output logic              dut_run,
  input  logic              dut_busy,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0] sram_rd_data,
  conv_job_launcher_if.master out_if,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e            state;
  logic [7:0]        job_count_q;
  logic [7:0]        job_cnt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] addr_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rd_pending;
  logic              rd_last_pending;

  logic [DATA_W:0]   head;
  logic              full;
  logic              empty;
  logic [1:0]        count;
  logic              pop;
  logic [2:0]        cnt_after;
  logic              issue;
  logic              last_idx;
  logic              start_acc;
  logic              timed_out;

  conv_rb_skid #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .reset_b   (reset_b),
    .push      (rd_pending),
    .push_data ({rd_last_pending, sram_rd_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign out_if.out_valid = !empty;
  assign out_if.out_data  = empty ? '0 : head[DATA_W-1:0];
  assign out_if.out_last  = !empty && head[DATA_W];
  assign pop              = out_if.out_valid && out_if.out_ready;

  // A new read may go out only if the buffer still has a slot for it after
  // this cycle's push/pop, with the word already in flight counted.
  assign cnt_after = {1'b0, count} + {2'b00, rd_pending} - {2'b00, pop};
  assign issue     = (state == S_READ) && (cnt_after <= 3'd1);
  assign last_idx  = (idx == len_q - ADDR_W'(1));
  assign start_acc = (state == S_IDLE) && start;
  assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT));

  assign sram_rd_addr = addr_q;

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state           <= S_IDLE;
      dut_run         <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      job_count_q     <= '0;
      job_cnt         <= '0;
      base_q          <= '0;
      len_q           <= '0;
      idx             <= '0;
      addr_q          <= '0;
      wait_cnt        <= '0;
      rd_pending      <= 1'b0;
      rd_last_pending <= 1'b0;
    end else begin
      done            <= 1'b0;
      rd_pending      <= issue;
      rd_last_pending <= issue && last_idx;
      wait_cnt        <= wait_cnt + WAIT_W'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            job_count_q <= job_count;
            base_q      <= result_base;
            len_q       <= result_len;
            job_cnt     <= '0;
            error       <= 1'b0;
            wait_cnt    <= '0;
            if (job_count == 8'd0) begin
              state <= S_DONE;
            end else begin
              state   <= S_RUN;
              dut_run <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (dut_busy) begin
            dut_run  <= 1'b0;
            state    <= S_WAIT_BUSY;
            wait_cnt <= '0;
          end else if (timed_out) begin
            dut_run  <= 1'b0;
            error    <= 1'b1;
            state    <= S_ERR;
            wait_cnt <= '0;
          end
        end

        S_WAIT_BUSY: begin
          if (!dut_busy) begin
            wait_cnt <= '0;
            if (len_q == '0) begin
              state <= S_DRAIN;
            end else begin
              state  <= S_READ;
              addr_q <= base_q;
              idx    <= '0;
            end
          end else if (timed_out) begin
            error    <= 1'b1;
            state    <= S_ERR;
            wait_cnt <= '0;
          end
        end

        S_READ: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            idx    <= idx + ADDR_W'(1);
            if (last_idx) begin
              state    <= S_DRAIN;
              wait_cnt <= '0;
            end
          end
        end

        // The job is finished once the last word has left the buffer.
        S_DRAIN: begin
          if (!rd_pending && empty) begin
            wait_cnt <= '0;
            job_cnt  <= job_cnt + 8'd1;
            if (job_cnt + 8'd1 == job_count_q) begin
              state <= S_DONE;
            end else begin
              state   <= S_RUN;
              dut_run <= 1'b1;
            end
          end
        end

        S_DONE: begin
          done     <= 1'b1;
          state    <= S_IDLE;
          wait_cnt <= '0;
        end

        S_ERR: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) assert (!(rd_pending && full && !pop));
  end

`ifdef CONV_LAUNCH_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b)        checksum_q <= '0;
    else if (start_acc) checksum_q <= '0;
    else if (pop)       checksum_q <= checksum_q + out_if.out_data;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_conv_job_launcher.sv
// Directed self-checking bench for conv_job_launcher with accelerator,
// SRAM and consumer models.
module tb_conv_job_launcher;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TO = 4095;
`ifdef CONV_LAUNCH_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_b;
  logic          start;
  logic [7:0]    job_count;
  logic [AW-1:0] result_base;
  logic [AW-1:0] result_len;
  logic          dut_run;
  logic          dut_busy;
  logic [AW-1:0] sram_rd_addr;
  logic [DW-1:0] sram_rd_data;
  logic          done;
  logic          error;
  logic [DW-1:0] checksum;

  conv_job_launcher_if #(.DATA_W(DW)) out_if ();

  conv_job_launcher #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .start        (start),
    .job_count    (job_count),
    .result_base  (result_base),
    .result_len   (result_len),
    .dut_run      (dut_run),
    .dut_busy     (dut_busy),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data),
    .out_if       (out_if.master),
    .done         (done),
    .error        (error),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Output SRAM: data valid the cycle after the address.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) sram_rd_data <= mem[sram_rd_addr];

  // Accelerator: raises busy once it sees run, holds it busy_len cycles.
  int busy_len = 10;
  bit acc_en   = 1'b1;
  initial begin
    dut_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_en && dut_run === 1'b1 && !dut_busy) begin
        dut_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 dut_busy = 1'b0;
      end
    end
  end

  // Consumer: 0 = always ready, 1 = toggle each cycle, 2 = never ready.
  int ready_mode = 0;
  initial begin
    out_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_if.out_ready = 1'b1;
        1:       out_if.out_ready = ~out_if.out_ready;
        default: out_if.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor, sampled mid-cycle.
  int            cyc = 0;
  logic [DW-1:0] rx_data [$];
  logic          rx_last [$];
  int            rx_cyc  [$];
  int            run_pulses, done_cycles, hold_errs, drop_errs;
  logic          prev_run, prev_busy, hold_armed, hold_last;
  logic [DW-1:0] hold_data;

  always @(negedge clk) begin
    cyc++;
    if (reset_b) begin
      hold_armed = 1'b0;
      prev_run   = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (out_if.out_valid && out_if.out_ready) begin
        rx_data.push_back(out_if.out_data);
        rx_last.push_back(out_if.out_last);
        rx_cyc.push_back(cyc);
      end
      if (hold_armed && !(out_if.out_valid === 1'b1 && out_if.out_data === hold_data &&
                          out_if.out_last === hold_last))
        hold_errs++;
      hold_armed = out_if.out_valid && !out_if.out_ready;
      hold_data  = out_if.out_data;
      hold_last  = out_if.out_last;
      if (dut_run && !prev_run) run_pulses++;
      if (prev_run && prev_busy && dut_run) drop_errs++;
      if (done) done_cycles++;
      prev_run  = dut_run;
      prev_busy = dut_busy;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] exp_ck(input logic [DW-1:0] s);
    return s & {DW{CK_EN}};
  endfunction

  task automatic clear_mon();
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
    run_pulses  = 0;
    done_cycles = 0;
    hold_errs   = 0;
    drop_errs   = 0;
  endtask

  // Start is held for one cycle; inputs are scrambled afterwards so any
  // failure to latch shows up as wrong data.
  task automatic do_start(input logic [7:0] jc, input logic [AW-1:0] base, input logic [AW-1:0] len);
    @(negedge clk);
    job_count   = jc;
    result_base = base;
    result_len  = len;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    job_count   = 8'hFF;
    result_base = '0;
    result_len  = '0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done: no done within %0d cycles", name, budget);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_b = 1'b1;
    start = 1'b0; job_count = '0; result_base = '0; result_len = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({dut_run, out_if.out_valid, out_if.out_last, done, error} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00000",
               {dut_run, out_if.out_valid, out_if.out_last, done, error});
    end
    tests++;
    if (sram_rd_addr !== '0) begin fails++; $display("FAIL reset_addr: got %h want 000", sram_rd_addr); end
    tests++;
    if (out_if.out_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0000", out_if.out_data); end
    tests++;
    if (checksum !== '0) begin fails++; $display("FAIL reset_checksum: got %h want 0000", checksum); end
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_job();
    logic [DW-1:0] exp_d [3];
    logic          exp_l [3];
    exp_d = '{16'h0001, 16'h0002, 16'h0003};
    exp_l = '{1'b0, 1'b0, 1'b1};
    clear_mon();
    busy_len = 10; ready_mode = 0;
    do_start(8'd1, 12'h100, 12'd3);
    tests++;
    if (dut_run !== 1'b1) begin fails++; $display("FAIL single_run_latency: got %b want 1", dut_run); end
    wait_done(300, "single");
    tests++;
    if (rx_data.size() != 3) begin
      fails++;
      $display("FAIL single_count: got %0d words want 3", rx_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (rx_data[i] !== exp_d[i] || rx_last[i] !== exp_l[i]) begin
          fails++;
          $display("FAIL single_word%0d: got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_d[i], exp_l[i]);
        end
      end
    end
    tests++;
    if (checksum !== exp_ck(16'h0006)) begin fails++; $display("FAIL single_checksum: got %h want %h", checksum, exp_ck(16'h0006)); end
    tests++;
    if (done_cycles != 1 || run_pulses != 1 || drop_errs != 0) begin
      fails++;
      $display("FAIL single_pulses: done=%0d run=%0d drop_err=%0d want 1 1 0", done_cycles, run_pulses, drop_errs);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [4];
    logic          exp_l [4];
    exp_d = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
    mem[12'h200] = 16'h1111;
    mem[12'h201] = 16'h2222;
    clear_mon();
    busy_len = 4; ready_mode = 1;
    do_start(8'd2, 12'h200, 12'd2);
    wait_done(400, "b2b");
    ready_mode = 0;
    tests++;
    if (rx_data.size() != 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d words want 4", rx_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (rx_data[i] !== exp_d[i] || rx_last[i] !== exp_l[i]) begin
          fails++;
          $display("FAIL b2b_word%0d: got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_d[i], exp_l[i]);
        end
      end
    end
    tests++;
    if (run_pulses != 2 || done_cycles != 1) begin
      fails++;
      $display("FAIL b2b_pulses: run=%0d done=%0d want 2 1", run_pulses, done_cycles);
    end
    tests++;
    if (hold_errs != 0) begin fails++; $display("FAIL b2b_hold: got %0d unstable stalls want 0", hold_errs); end
    tests++;
    if (checksum !== exp_ck(16'h6666)) begin fails++; $display("FAIL b2b_checksum: got %h want %h", checksum, exp_ck(16'h6666)); end
  endtask

  task automatic test_zero_jobs();
    clear_mon();
    do_start(8'd0, 12'h100, 12'd3);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL zero_done_early: got %b want 0", done); end
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL zero_done_pulse: got %b want 1", done); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL zero_done_width: got %b want 0", done); end
    repeat (3) @(negedge clk);
    tests++;
    if (run_pulses != 0) begin fails++; $display("FAIL zero_run: got %0d run pulses want 0", run_pulses); end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_mon();
    acc_en = 1'b0;
    do_start(8'd1, 12'h100, 12'd1);
    while (dut_run === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != TO + 1) begin fails++; $display("FAIL timeout_cycles: got %0d run cycles want %0d", n, TO + 1); end
    tests++;
    if (error !== 1'b1) begin fails++; $display("FAIL timeout_error: got %b want 1", error); end
    repeat (2) @(negedge clk);
    tests++;
    if (error !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b want 1", error); end
    acc_en = 1'b1; busy_len = 2;
    do_start(8'd1, 12'h100, 12'd1);
    tests++;
    if (error !== 1'b0 || dut_run !== 1'b1) begin
      fails++;
      $display("FAIL timeout_restart: error=%b run=%b want 0 1", error, dut_run);
    end
    wait_done(200, "timeout_restart");
    tests++;
    if (rx_data.size() != 1 || rx_data[0] !== 16'h0001 || rx_last[0] !== 1'b1) begin
      fails++;
      $display("FAIL timeout_restart_word: got %0d words first %h want 1 word 0001",
               rx_data.size(), (rx_data.size() > 0) ? rx_data[0] : 16'hxxxx);
    end
  endtask

  task automatic test_addr_wrap();
    logic [DW-1:0] exp_d [4];
    exp_d = '{16'hAFFE, 16'hAFFF, 16'hA000, 16'hA001};
    mem[12'hFFE] = 16'hAFFE;
    mem[12'hFFF] = 16'hAFFF;
    mem[12'h000] = 16'hA000;
    mem[12'h001] = 16'hA001;
    clear_mon();
    busy_len = 3; ready_mode = 0;
    do_start(8'd1, 12'hFFE, 12'd4);
    wait_done(200, "wrap");
    tests++;
    if (rx_data.size() != 4) begin
      fails++;
      $display("FAIL wrap_count: got %0d words want 4", rx_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (rx_data[i] !== exp_d[i] || rx_last[i] !== (i == 3)) begin
          fails++;
          $display("FAIL wrap_word%0d: got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_d[i], (i == 3));
        end
      end
      tests++;
      if (rx_cyc[3] - rx_cyc[0] != 3) begin
        fails++;
        $display("FAIL wrap_throughput: got %0d cycles for 4 words want 3", rx_cyc[3] - rx_cyc[0]);
      end
    end
    tests++;
    if (checksum !== exp_ck(16'h9FFE)) begin fails++; $display("FAIL wrap_checksum: got %h want %h", checksum, exp_ck(16'h9FFE)); end
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    clear_mon();
    busy_len = 3; ready_mode = 2;
    do_start(8'd1, 12'h100, 12'd3);
    while (out_if.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (out_if.out_valid !== 1'b1) begin fails++; $display("FAIL midreset_setup: got valid %b want 1", out_if.out_valid); end
    reset_b = 1'b1;
    #1;
    tests++;
    if ({dut_run, out_if.out_valid, out_if.out_last, done, error} !== 5'b0) begin
      fails++;
      $display("FAIL midreset_flags: got %b want 00000",
               {dut_run, out_if.out_valid, out_if.out_last, done, error});
    end
    tests++;
    if (sram_rd_addr !== '0 || out_if.out_data !== '0 || checksum !== '0) begin
      fails++;
      $display("FAIL midreset_values: addr=%h data=%h ck=%h want 0", sram_rd_addr, out_if.out_data, checksum);
    end
    @(negedge clk);
    reset_b = 1'b0;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    clear_mon();
    do_start(8'd1, 12'h100, 12'd3);
    wait_done(300, "midreset_rerun");
    tests++;
    if (rx_data.size() != 3 || rx_data[0] !== 16'h0001 || rx_data[1] !== 16'h0002 ||
        rx_data[2] !== 16'h0003 || rx_last[2] !== 1'b1) begin
      fails++;
      $display("FAIL midreset_rerun: got %0d words want 0001 0002 0003", rx_data.size());
    end
    tests++;
    if (checksum !== exp_ck(16'h0006)) begin fails++; $display("FAIL midreset_checksum: got %h want %h", checksum, exp_ck(16'h0006)); end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    mem[12'h100] = 16'h0001;
    mem[12'h101] = 16'h0002;
    mem[12'h102] = 16'h0003;
    clear_mon();
    test_reset();
    test_single_job();
    test_back_to_back();
    test_zero_jobs();
    test_timeout();
    test_addr_wrap();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
